// File: rtl/cerradura_2b_pkg.sv
// Shared types and constants for the 2-bit combination lock.
// Imported by the lock controller and its helpers.
package cerradura_2b_pkg;

    localparam int DIGIT_W = 2;

    localparam logic [DIGIT_W-1:0] CODE_RST = '0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ENTER   = 4'b0010,
        ST_OPEN    = 4'b0100,
        ST_LOCKOUT = 4'b1000
    } state_e;

    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cerradura_2b_igual.sv
// 2-bit equality comparator: high when {a,b} equals {c,d}.
// Purely combinational; one instance serves the lock.
module igual_2b2b (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    output logic eq_o
);

    assign eq_o = (a_i ~^ c_i) & (b_i ~^ d_i);

endmodule

// File: rtl/cerradura_2b.sv
// Sequential 2-bit combination lock with programming,
// timed unlock window and lockout after repeated failures.
module cerradura_2b
    import cerradura_2b_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int OPEN_CYCLES    = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIGIT_W-1:0]         digit_in,
    input  logic                       digit_valid,
    output logic                       digit_ready,
    input  logic                       prog_en,
    input  logic                       abort,
    output logic                       unlocked,
    output logic                       locked_out,
    output logic [$clog2(DIGITS)-1:0]  idx,
    output logic [2:0]                 fail_count
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int TMR_W = clog2_max(OPEN_CYCLES, LOCKOUT_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMR_W-1:0] T_OPEN   = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       FAIL_MAX = 3'(MAX_FAILS);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [2:0]           fail_q, fail_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 mis_q, mis_d;
    logic [DIGIT_W-1:0]   code_q [DIGITS];
    logic [DIGIT_W-1:0]   code_d [DIGITS];

    logic [DIGIT_W-1:0]   code_sel;
    logic                 match;
    logic                 accept;
    logic [IDX_W-1:0]     idx_inc;
    logic                 bad_entry;

    assign code_sel  = code_q[idx_q];
    assign accept    = digit_valid & digit_ready;
    assign idx_inc   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    assign bad_entry = mis_q | ~match;

    igual_2b2b u_cmp (
        .a_i  (digit_in[1]),
        .b_i  (digit_in[0]),
        .c_i  (code_sel[1]),
        .d_i  (code_sel[0]),
        .eq_o (match)
    );

    // State, counters, timer and code storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fail_q  <= '0;
            tmr_q   <= '0;
            mis_q   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                code_q[i] <= CODE_RST;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            tmr_q   <= tmr_d;
            mis_q   <= mis_d;
            code_q  <= code_d;
        end
    end

    // Next-state: entry sequencing, verdict, programming, timers
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        mis_d   = mis_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ENTER;
                    idx_d   = IDX_ONE;
                    mis_d   = ~match;
                end
            end
            ST_ENTER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end else if (accept) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_ONE;
                        mis_d = bad_entry;
                    end else begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!bad_entry) begin
                            state_d = ST_OPEN;
                            tmr_d   = T_OPEN;
                            fail_d  = '0;
                        end else if ((fail_q + 3'd1) < FAIL_MAX) begin
                            state_d = ST_IDLE;
                            fail_d  = fail_q + 3'd1;
                        end else begin
                            state_d = ST_LOCKOUT;
                            tmr_d   = T_LOCK;
                            fail_d  = FAIL_MAX;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (accept) begin
                    code_d[idx_q] = digit_in;
                    idx_d         = idx_inc;
                    tmr_d         = T_OPEN;
                end else if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                mis_d   = 1'b0;
            end
        endcase
    end

    // Outputs: status straight from state flops, ready gated by inputs
    always_comb begin
        unlocked    = (state_q == ST_OPEN);
        locked_out  = (state_q == ST_LOCKOUT);
        idx         = idx_q;
        fail_count  = fail_q;
        digit_ready = 1'b0;
        case (state_q)
            ST_IDLE:    digit_ready = ~abort;
            ST_ENTER:   digit_ready = ~abort;
            ST_OPEN:    digit_ready = prog_en & ~abort;
            ST_LOCKOUT: digit_ready = 1'b0;
            default:    digit_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cerradura_2b.sv
// Randomized scoreboard bench for cerradura_2b with a
// sequence-level reference model of the lock.
module tb_cerradura_2b;

    localparam int DIG    = 4;
    localparam int OPEN_C = 8;
    localparam int LOCK_C = 16;
    localparam int MAXF   = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ENTER = 1;
    localparam int M_OPEN  = 2;
    localparam int M_LOCK  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] digit_in = 2'b00;
    logic       digit_valid = 1'b0;
    logic       prog_en = 1'b0;
    logic       abort = 1'b0;
    logic       digit_ready;
    logic       unlocked;
    logic       locked_out;
    logic [1:0] idx;
    logic [2:0] fail_count;

    always #5 clk = ~clk;

    cerradura_2b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .prog_en     (prog_en),
        .abort       (abort),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .idx         (idx),
        .fail_count  (fail_count)
    );

    typedef struct {
        int ul;
        int lo;
        int rdy;
        int ix;
        int fc;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;

    // reference model: mode, stored code, digits typed so far
    int         m_mode = M_IDLE;
    logic [1:0] m_code[DIG];
    logic [1:0] m_ent[$];
    int         m_fail = 0;
    int         m_left = 0;
    int         m_wptr = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // monitor: compare DUT outputs against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("unlocked", int'(unlocked), e.ul);
            chk("locked_out", int'(locked_out), e.lo);
            chk("digit_ready", int'(digit_ready), e.rdy);
            chk("idx", int'(idx), e.ix);
            chk("fail_count", int'(fail_count), e.fc);
        end
    end

    function automatic bit code_ok();
        for (int i = 0; i < DIG; i++) begin
            if (m_ent[i] != m_code[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_fail = 0;
        m_left = 0;
        m_wptr = 0;
        m_ent.delete();
        for (int i = 0; i < DIG; i++) m_code[i] = 2'b00;
    endfunction

    // one clock cycle: drive, predict, advance model
    task automatic cyc(input bit v, input logic [1:0] d,
                       input bit pe, input bit ab);
        exp_t e;
        bit   rdy;
        bit   acc;
        digit_valid = v;
        digit_in    = d;
        prog_en     = pe;
        abort       = ab;
        case (m_mode)
            M_IDLE, M_ENTER: rdy = !ab;
            M_OPEN:          rdy = pe && !ab;
            default:         rdy = 1'b0;
        endcase
        acc   = v && rdy;
        e.ul  = (m_mode == M_OPEN) ? 1 : 0;
        e.lo  = (m_mode == M_LOCK) ? 1 : 0;
        e.rdy = rdy ? 1 : 0;
        e.ix  = (m_mode == M_ENTER) ? m_ent.size() :
                (m_mode == M_OPEN)  ? m_wptr : 0;
        e.fc  = m_fail;
        expq.push_back(e);
        case (m_mode)
            M_IDLE: begin
                if (acc) begin
                    m_ent.delete();
                    m_ent.push_back(d);
                    m_mode = M_ENTER;
                end
            end
            M_ENTER: begin
                if (ab) begin
                    m_ent.delete();
                    m_mode = M_IDLE;
                end else if (acc) begin
                    m_ent.push_back(d);
                    if (m_ent.size() == DIG) begin
                        if (code_ok()) begin
                            m_mode = M_OPEN;
                            m_left = OPEN_C - 1;
                            m_fail = 0;
                            m_wptr = 0;
                        end else begin
                            m_fail++;
                            if (m_fail >= MAXF) begin
                                m_mode = M_LOCK;
                                m_left = LOCK_C - 1;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                        m_ent.delete();
                    end
                end
            end
            M_OPEN: begin
                if (ab) begin
                    m_mode = M_IDLE;
                    m_wptr = 0;
                end else if (acc) begin
                    m_code[m_wptr] = d;
                    m_wptr = (m_wptr + 1) % DIG;
                    m_left = OPEN_C - 1;
                end else if (m_left == 0) begin
                    m_mode = M_IDLE;
                    m_wptr = 0;
                end else begin
                    m_left--;
                end
            end
            default: begin
                if (m_left == 0) begin
                    m_mode = M_IDLE;
                    m_fail = 0;
                end else begin
                    m_left--;
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic enter4(input logic [7:0] s, input bit pe);
        logic [7:0] t;
        t = s;
        for (int i = 0; i < DIG; i++) begin
            cyc(1'b1, t[7:6], pe, 1'b0);
            t = t << 2;
        end
    endtask

    // asynchronous reset mid-cycle, checked before any clock edge
    task automatic reset_now();
        digit_valid = 1'b0;
        prog_en     = 1'b0;
        abort       = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_locked_out", int'(locked_out), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_fail_count", int'(fail_count), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         v;
        bit         pe;
        bit         ab;
        logic [1:0] d;
        model_reset();
        @(posedge clk);
        #1;
        reset_now();
        // correct default entry opens for the full window
        enter4(8'b00_00_00_00, 1'b0);
        idle(10);
        // program a new code while open
        enter4(8'b00_00_00_00, 1'b0);
        enter4(8'b10_01_11_00, 1'b1);
        idle(10);
        enter4(8'b10_01_11_00, 1'b0);
        idle(10);
        enter4(8'b00_00_00_00, 1'b0);
        idle(2);
        // three failures on default code cause lockout
        reset_now();
        for (int k = 0; k < MAXF; k++) begin
            enter4(8'b01_00_00_00, 1'b0);
            idle(1);
        end
        for (int i = 0; i < LOCK_C + 2; i++) begin
            cyc(1'b1, 2'($urandom), 1'($urandom), 1'($urandom));
        end
        // abort with a simultaneous digit, then a clean entry
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 1'b0, 1'b1);
        cyc(1'b1, 2'b00, 1'b0, 1'b1);
        enter4(8'b00_00_00_00, 1'b0);
        idle(10);
        // reset in the middle of a lockout
        for (int k = 0; k < MAXF; k++) enter4(8'b11_00_00_00, 1'b0);
        idle(4);
        reset_now();
        // program 1111, start an entry, reset, default code works
        enter4(8'b00_00_00_00, 1'b0);
        enter4(8'b11_11_11_11, 1'b1);
        idle(9);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);
        reset_now();
        enter4(8'b00_00_00_00, 1'b0);
        idle(9);
        // randomized traffic biased toward the correct code
        for (int n = 0; n < 1500; n++) begin
            v  = ($urandom % 3) != 0;
            ab = ($urandom % 20) == 0;
            pe = ($urandom % 3) == 0;
            if (m_mode == M_OPEN || ($urandom % 5) == 0)
                d = 2'($urandom);
            else if (m_mode == M_ENTER)
                d = m_code[m_ent.size()];
            else
                d = m_code[0];
            if (($urandom % 400) == 0) reset_now();
            else cyc(v, d, pe, ab);
        end
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
